// File: rtl/sysctl_csr_bank_pkg.sv
// Shared constants and decode helpers for the system-control CSR bank.
// Word offsets are byte address bits [7:2]; the region enum names each decoded target.
package sysctl_csr_pkg;

  localparam logic [5:0]  ADR_ID        = 6'h00;  // 0x00
  localparam logic [5:0]  ADR_IRQ_PEND  = 6'h01;  // 0x04
  localparam logic [5:0]  ADR_IRQ_MASK  = 6'h02;  // 0x08
  localparam logic [5:0]  ADR_PULSE     = 6'h03;  // 0x0C
  localparam logic [5:0]  ADR_CTL_BASE  = 6'h10;  // 0x40
  localparam logic [5:0]  ADR_STAT_BASE = 6'h20;  // 0x80

  localparam logic [31:0] DEFAULT_ID    = 32'h5C5C_0002;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ID,
    REG_PEND,
    REG_MASK,
    REG_PULSE,
    REG_CTL,
    REG_STAT
  } reg_sel_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/sysctl_csr_bank_if.sv
// Pipelined Wishbone slave bundle for the CSR bank; the master drives the request,
// the slave returns ack/stall/read data.
interface sysctl_csr_bank_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        stall;

  modport master (output adr, dat_w, sel, cyc, stb, we, input  dat_r, ack, stall);
  modport slave  (input  adr, dat_w, sel, cyc, stb, we, output dat_r, ack, stall);
endinterface

// File: rtl/sysctl_irq_ctrl.sv
// Rising-edge interrupt capture with W1C pending, RW mask and a registered request.
// pend updates one edge after the source rises; irq follows pend/mask by one more edge.
module sysctl_irq_ctrl #(
  parameter int g_num_irq = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [g_num_irq-1:0] src,
  input  logic                 mask_we,
  input  logic                 pend_we,
  input  logic [g_num_irq-1:0] wdat,
  input  logic [g_num_irq-1:0] wmask,
  output logic [g_num_irq-1:0] pend,
  output logic [g_num_irq-1:0] mask,
  output logic                 irq
);

  logic [g_num_irq-1:0] prev;
  logic [g_num_irq-1:0] rise;
  logic [g_num_irq-1:0] clr;

  assign rise = src & ~prev;
  assign clr  = pend_we ? (wdat & wmask) : '0;

  // Rise is OR-ed in after the clear so a simultaneous set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      prev <= src;
      pend <= (pend & ~clr) | rise;
      if (mask_we)
        mask <= (mask & ~wmask) | (wdat & wmask);
      irq  <= |(pend & mask);
    end
  end

endmodule

// File: rtl/sysctl_csr_bank.sv
// Wishbone CSR bank: RW control words, RO status words, pulse strobes and an IRQ block.
// One-cycle ack per accepted strobe, never stalls; ack is dropped if cyc falls first.
module sysctl_csr_bank
  import sysctl_csr_pkg::*;
#(
  parameter int          g_num_ctl   = 8,
  parameter int          g_num_stat  = 4,
  parameter int          g_num_irq   = 8,
  parameter logic [31:0] g_ctl_reset = 32'h0,
  parameter logic [31:0] g_id        = DEFAULT_ID
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  sysctl_csr_bank_if.slave        wb,
  output logic [32*g_num_ctl-1:0]  ctl_o,
  input  logic [32*g_num_stat-1:0] stat_i,
  output logic [31:0]              pulse_o,
  input  logic [g_num_irq-1:0]     irq_src_i,
  output logic                     irq_o
);

  if (g_num_ctl < 1 || g_num_ctl > 16 || g_num_stat < 1 || g_num_stat > 16 ||
      g_num_irq < 1 || g_num_irq > 32) begin : g_bad_param
    $error("sysctl_csr_bank: parameter out of range");
  end

  localparam logic [4:0] NUM_CTL  = 5'(g_num_ctl);
  localparam logic [4:0] NUM_STAT = 5'(g_num_stat);

  logic [5:0]           word;
  logic [3:0]           idx;
  reg_sel_e             region;
  logic                 acc;
  logic                 wr;
  logic [31:0]          wm;
  logic [31:0]          rd_mux;
  logic [31:0]          ctl_q [g_num_ctl];
  logic                 ack_q;
  logic [31:0]          dat_q;
  logic [g_num_irq-1:0] pend_bits;
  logic [g_num_irq-1:0] mask_bits;
  logic [31:0]          pend_rd;
  logic [31:0]          mask_rd;
  logic                 unused_adr;

  assign word       = wb.adr[7:2];
  assign idx        = word[3:0];
  assign acc        = wb.cyc & wb.stb;
  assign wr         = acc & wb.we;
  assign wm         = byte_mask(wb.sel);
  assign unused_adr = ^{wb.adr[31:8], wb.adr[1:0]};

  always_comb begin
    region = REG_NONE;
    if (word == ADR_ID)
      region = REG_ID;
    else if (word == ADR_IRQ_PEND)
      region = REG_PEND;
    else if (word == ADR_IRQ_MASK)
      region = REG_MASK;
    else if (word == ADR_PULSE)
      region = REG_PULSE;
    else if (word[5:4] == ADR_CTL_BASE[5:4] && {1'b0, idx} < NUM_CTL)
      region = REG_CTL;
    else if (word[5:4] == ADR_STAT_BASE[5:4] && {1'b0, idx} < NUM_STAT)
      region = REG_STAT;
  end

  always_comb begin
    pend_rd = '0;
    mask_rd = '0;
    pend_rd[g_num_irq-1:0] = pend_bits;
    mask_rd[g_num_irq-1:0] = mask_bits;
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_ID:   rd_mux = g_id;
      REG_PEND: rd_mux = pend_rd;
      REG_MASK: rd_mux = mask_rd;
      REG_CTL: begin
        for (int i = 0; i < g_num_ctl; i++)
          if (idx == 4'(i)) rd_mux = ctl_q[i];
      end
      REG_STAT: begin
        for (int i = 0; i < g_num_stat; i++)
          if (idx == 4'(i)) rd_mux = stat_i[32*i +: 32];
      end
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < g_num_ctl; i++)
        ctl_q[i] <= g_ctl_reset;
    end else if (wr && region == REG_CTL) begin
      for (int i = 0; i < g_num_ctl; i++)
        if (idx == 4'(i))
          ctl_q[i] <= (ctl_q[i] & ~wm) | (wb.dat_w & wm);
    end
  end

  // Read data only moves on accepted reads so it holds between accesses.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      pulse_o <= '0;
    end else begin
      ack_q   <= acc;
      if (acc && !wb.we)
        dat_q <= rd_mux;
      pulse_o <= (wr && region == REG_PULSE) ? (wb.dat_w & wm) : '0;
    end
  end

  for (genvar i = 0; i < g_num_ctl; i++) begin : g_ctl_out
    assign ctl_o[32*i +: 32] = ctl_q[i];
  end

  assign wb.ack   = ack_q & wb.cyc;
  assign wb.stall = 1'b0;
  assign wb.dat_r = dat_q;

  sysctl_irq_ctrl #(
    .g_num_irq (g_num_irq)
  ) u_irq (
    .clk     (clk_sys_i),
    .rst     (rst_i),
    .src     (irq_src_i),
    .mask_we (wr && region == REG_MASK),
    .pend_we (wr && region == REG_PEND),
    .wdat    (wb.dat_w[g_num_irq-1:0]),
    .wmask   (wm[g_num_irq-1:0]),
    .pend    (pend_bits),
    .mask    (mask_bits),
    .irq     (irq_o)
  );

endmodule

// File: tb/tb_sysctl_csr_bank.sv
// Bench for sysctl_csr_bank: directed scenarios plus random traffic against a
// transaction-level model of the register map.
module tb_sysctl_csr_bank;

  localparam int          NC = 8;
  localparam int          NS = 4;
  localparam int          NI = 8;
  localparam logic [31:0] ID = 32'h5C5C_0002;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sysctl_csr_bank_if bus();

  logic [32*NC-1:0] ctl_o;
  logic [32*NS-1:0] stat;
  logic [31:0]      pulse;
  logic [NI-1:0]    src;
  logic             irq;

  sysctl_csr_bank dut (
    .clk_sys_i (clk),
    .rst_i     (rst),
    .wb        (bus),
    .ctl_o     (ctl_o),
    .stat_i    (stat),
    .pulse_o   (pulse),
    .irq_src_i (src),
    .irq_o     (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference state, updated once per bus cycle from the register-map rules.
  logic [31:0]   m_ctl [NC];
  logic [NI-1:0] m_mask, m_pend, m_prev;
  logic          m_irq, m_ack;
  logic [31:0]   m_dat, m_pulse;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_ctl[i] = 32'h0;
    m_mask = '0; m_pend = '0; m_prev = '0;
    m_irq = 0; m_ack = 0; m_dat = 0; m_pulse = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o;
    o = int'(a[7:0]) & 'hFC;
    if (o == 0)                         return ID;
    if (o == 4)                         return {24'b0, m_pend};
    if (o == 8)                         return {24'b0, m_mask};
    if (o >= 64 && o < 64 + 4*NC)        return m_ctl[(o-64)/4];
    if (o >= 128 && o < 128 + 4*NS)      return stat[32*((o-128)/4) +: 32];
    return 32'h0;
  endfunction

  function automatic logic [32*NC-1:0] m_ctl_vec();
    logic [32*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[32*i +: 32] = m_ctl[i];
    return v;
  endfunction

  task automatic cycle(input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] wm;
    logic [NI-1:0] clr, rise;
    int o;
    logic acc;
    @(negedge clk);
    bus.cyc = cyc; bus.stb = stb; bus.we = we;
    bus.adr = adr; bus.dat_w = dat; bus.sel = sel;
    acc = cyc && stb;
    o = int'(adr[7:0]) & 'hFC;
    wm = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) wm[8*b +: 8] = 8'hFF;
    m_irq = |(m_pend & m_mask);
    if (acc && !we) m_dat = m_read(adr);
    rise = src & ~m_prev;
    clr = (acc && we && o == 4) ? NI'(dat & wm) : '0;
    m_pend = (m_pend & ~clr) | rise;
    if (acc && we && o == 8) m_mask = (m_mask & ~NI'(wm)) | NI'(dat & wm);
    if (acc && we && o >= 64 && o < 64 + 4*NC)
      m_ctl[(o-64)/4] = (m_ctl[(o-64)/4] & ~wm) | (dat & wm);
    m_pulse = (acc && we && o == 12) ? (dat & wm) : 32'h0;
    m_ack = acc;
    m_prev = src;
    @(posedge clk); #1;
    chk("ack", 256'(bus.ack), 256'(m_ack));
    chk("stall", 256'(bus.stall), 256'(0));
    chk("dat", 256'(bus.dat_r), 256'(m_dat));
    chk("pulse", 256'(pulse), 256'(m_pulse));
    chk("irq", 256'(irq), 256'(m_irq));
    chk("ctl", 256'(ctl_o), 256'(m_ctl_vec()));
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1, 1, 0, a, $urandom, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cycle(1, 1, 1, a, d, s);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1;
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = 0; bus.dat_w = 0; bus.sel = 0;
    src = '0;
    stat = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    model_reset();
    #12;
    chk("rst_ack", 256'(bus.ack), 256'(0));
    chk("rst_dat", 256'(bus.dat_r), 256'(0));
    chk("rst_ctl", 256'(ctl_o), 256'(0));
    chk("rst_pulse", 256'(pulse), 256'(0));
    chk("rst_irq", 256'(irq), 256'(0));
    @(negedge clk); rst = 0;

    // Scenario 1: ID, CTL0, unmapped
    idle();
    rd(32'h00);           chk("id_val", 256'(bus.dat_r), 256'(ID));
    rd(32'h40);           chk("ctl0_rst", 256'(bus.dat_r), 256'(0));
    rd(32'hFC);           chk("unmapped_rd", 256'(bus.dat_r), 256'(0));
    rd(32'h00);
    bus.cyc = 0; #1;      chk("ack_gated", 256'(bus.ack), 256'(0));
    idle();

    // Scenario 2: byte-lane write
    wr(32'h44, 32'hA5A5_1234, 4'b0101);
    chk("ctl1_sel", 256'(ctl_o[63:32]), 256'(32'h00A5_0034));
    rd(32'h44);           chk("ctl1_rb", 256'(bus.dat_r), 256'(32'h00A5_0034));

    // Scenario 3: back-to-back writes, then readback
    for (int i = 0; i < 4; i++) wr(32'h40 + 4*i, 32'hC0DE_0000 + i, 4'hF);
    for (int i = 0; i < 4; i++) rd(32'h40 + 4*i);
    rd(32'h80);           chk("stat0", 256'(bus.dat_r), 256'(32'h1111_0000));

    // Scenario 4: pulse
    wr(32'h0C, 32'h8000_0001, 4'hF);
    chk("pulse_on", 256'(pulse), 256'(32'h8000_0001));
    idle();               chk("pulse_off", 256'(pulse), 256'(0));
    rd(32'h0C);           chk("pulse_rd0", 256'(bus.dat_r), 256'(0));

    // Scenario 5: interrupt edge, mask, W1C against a new edge
    wr(32'h08, 32'h04, 4'hF);
    src[2] = 1; idle();
    idle();               chk("irq_on", 256'(irq), 256'(1));
    src[2] = 0; idle();
    src[2] = 1; wr(32'h04, 32'h04, 4'hF);
    rd(32'h04);           chk("pend_kept", 256'(bus.dat_r), 256'(32'h4));
    wr(32'h04, 32'h04, 4'hF);
    idle();
    rd(32'h04);           chk("pend_clr", 256'(bus.dat_r), 256'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 3)) << 2;
        1: a = 32'h40 + 4 * $urandom_range(0, 15);
        2: a = 32'h80 + 4 * $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) src = src ^ NI'($urandom);
      stat = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            a, $urandom, 4'($urandom));
    end

    // Scenario 6: reset during a STAT read with irq asserted
    src = '0;
    wr(32'h08, 32'h04, 4'hF);
    wr(32'h40, 32'hDEAD_BEEF, 4'hF);
    idle();
    src[2] = 1; idle();
    idle();               chk("irq_pre_rst", 256'(irq), 256'(1));
    @(negedge clk);
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = 32'h80;
    #2 rst = 1;
    #1;
    chk("async_ctl", 256'(ctl_o), 256'(0));
    chk("async_irq", 256'(irq), 256'(0));
    @(posedge clk); #1;
    chk("rst_no_ack", 256'(bus.ack), 256'(0));
    chk("rst_dat0", 256'(bus.dat_r), 256'(0));
    @(negedge clk);
    rst = 0; bus.cyc = 0; bus.stb = 0;
    model_reset();
    idle();
    rd(32'h04);           chk("pend_after_rst", 256'(bus.dat_r), 256'(32'h4));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
